// File: rtl/frame_capture_scheduler_if.sv
// Frame capture scheduler bus: decoder/writer/host strobes in,
// grants, capture start, frame status and error counters out.
interface frame_capture_scheduler_if;
   logic       enable;
   logic       frame_done;
   logic       cap_done;
   logic       host_rd_req;
   logic       host_rd_done;
   logic       cap_start;
   logic       cap_grant;
   logic       host_grant;
   logic       frame_ready;
   logic [7:0] drop_count;
   logic       cap_timeout;

   modport master (
      output enable, frame_done, cap_done, host_rd_req, host_rd_done,
      input  cap_start, cap_grant, host_grant, frame_ready,
      input  drop_count, cap_timeout
   );

   modport slave (
      input  enable, frame_done, cap_done, host_rd_req, host_rd_done,
      output cap_start, cap_grant, host_grant, frame_ready,
      output drop_count, cap_timeout
   );
endinterface

// File: rtl/frame_capture_scheduler.sv
// Periodic frame capture scheduler with single-owner frame-buffer arbitration.
// Ports: clk, reset (async, active-high), bus (slave modport of
//   frame_capture_scheduler_if: enable, frame_done, cap_done, host_rd_req,
//   host_rd_done in; cap_start, cap_grant, host_grant, frame_ready,
//   drop_count, cap_timeout out).
module frame_capture_scheduler #(
   parameter int FRAME_RATE     = 30,
   parameter int INTERVAL_SEC   = 5,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input logic                     clk,
   input logic                     reset,
   frame_capture_scheduler_if.slave bus
);

   localparam int INTERVAL = FRAME_RATE * INTERVAL_SEC;
   localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(INTERVAL - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      READ    = 2'd2
   } state_t;

   state_t        state;
   state_t        state_d;
   logic [CW-1:0] frame_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          capture_due;
   logic          frame_ready;
   logic          cap_start;
   logic          cap_grant;
   logic          host_grant;
   logic [7:0]    drop_count;
   logic          cap_timeout;

   logic          frame_tick;
   logic          due_event;
   logic          drop_event;
   logic          take;
   logic          ready_set;
   logic          ready_clr;
   logic          tmo_hit;

   assign frame_tick = bus.enable & bus.frame_done;
   assign due_event  = frame_tick & (frame_cnt == CNT_LAST);
   // Only one capture may be pending; any further one is lost.
   assign drop_event = due_event & capture_due;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (frame_tick) begin
         frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + CW'(1);
      end
   end

   always_comb begin
      state_d   = state;
      take      = 1'b0;
      ready_set = 1'b0;
      ready_clr = 1'b0;
      tmo_hit   = 1'b0;
      unique case (state)
         IDLE: begin
            if (capture_due) begin
               state_d = CAPTURE;
               take    = 1'b1;
            end else if (bus.host_rd_req && frame_ready) begin
               state_d   = READ;
               ready_clr = 1'b1;
            end
         end
         CAPTURE: begin
            // Completion wins over a timeout landing on the same cycle.
            if (bus.cap_done) begin
               state_d   = IDLE;
               ready_set = 1'b1;
            end else if (tmo_cnt == TMO_LAST) begin
               state_d = IDLE;
               tmo_hit = 1'b1;
            end
         end
         READ: begin
            if (bus.host_rd_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cap_start  <= 1'b0;
         cap_grant  <= 1'b0;
         host_grant <= 1'b0;
         tmo_cnt    <= '0;
      end else begin
         state      <= state_d;
         cap_start  <= take;
         cap_grant  <= (state_d == CAPTURE);
         host_grant <= (state_d == READ);
         if ((state == CAPTURE) && (state_d == CAPTURE)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end else begin
            tmo_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         capture_due <= 1'b0;
         frame_ready <= 1'b0;
         drop_count  <= '0;
         cap_timeout <= 1'b0;
      end else begin
         if (due_event && !capture_due) begin
            capture_due <= 1'b1;
         end else if (take) begin
            capture_due <= 1'b0;
         end
         if (ready_set) begin
            frame_ready <= 1'b1;
         end else if (ready_clr) begin
            frame_ready <= 1'b0;
         end
         if (drop_event && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
         end
         if (tmo_hit) begin
            cap_timeout <= 1'b1;
         end
      end
   end

   assign bus.cap_start   = cap_start;
   assign bus.cap_grant   = cap_grant;
   assign bus.host_grant  = host_grant;
   assign bus.frame_ready = frame_ready;
   assign bus.drop_count  = drop_count;
   assign bus.cap_timeout = cap_timeout;

endmodule

// File: tb/tb_frame_capture_scheduler.sv
// Directed bench for frame_capture_scheduler (INTERVAL=4, timeout 16).
// Table-driven vectors plus multi-cycle sequences for the corner cases.
module tb_frame_capture_scheduler;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   frame_capture_scheduler_if bus ();

   frame_capture_scheduler #(
      .FRAME_RATE    (2),
      .INTERVAL_SEC  (2),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // in  = {enable, frame_done, cap_done, host_rd_req, host_rd_done}
   // out = {cap_start, cap_grant, host_grant, frame_ready, cap_timeout}
   typedef struct {
      logic [4:0] in;
      logic [4:0] out;
      logic [7:0] dc;
   } vec_t;

   vec_t vecs [22];

   function automatic vec_t mk(logic [4:0] in, logic [4:0] out,
                               logic [7:0] dc);
      vec_t v;
      v.in  = in;
      v.out = out;
      v.dc  = dc;
      return v;
   endfunction

   function automatic logic [12:0] outs();
      return {bus.cap_start, bus.cap_grant, bus.host_grant,
              bus.frame_ready, bus.cap_timeout, bus.drop_count};
   endfunction

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] in);
      bus.enable       = in[4];
      bus.frame_done   = in[3];
      bus.cap_done     = in[2];
      bus.host_rd_req  = in[1];
      bus.host_rd_done = in[0];
   endtask

   task automatic step(input logic [4:0] in);
      drive(in);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      drive(5'b00000);

      vecs[0]  = mk(5'b11000, 5'b00000, 8'd0);
      vecs[1]  = mk(5'b11000, 5'b00000, 8'd0);
      vecs[2]  = mk(5'b11000, 5'b00000, 8'd0);
      vecs[3]  = mk(5'b11000, 5'b00000, 8'd0);
      vecs[4]  = mk(5'b10000, 5'b11000, 8'd0);
      vecs[5]  = mk(5'b10000, 5'b01000, 8'd0);
      vecs[6]  = mk(5'b10100, 5'b00010, 8'd0);
      vecs[7]  = mk(5'b11000, 5'b00010, 8'd0);
      vecs[8]  = mk(5'b11000, 5'b00010, 8'd0);
      vecs[9]  = mk(5'b11000, 5'b00010, 8'd0);
      vecs[10] = mk(5'b11000, 5'b00010, 8'd0);
      vecs[11] = mk(5'b10010, 5'b11010, 8'd0);
      vecs[12] = mk(5'b10010, 5'b01010, 8'd0);
      vecs[13] = mk(5'b10110, 5'b00010, 8'd0);
      vecs[14] = mk(5'b10010, 5'b00100, 8'd0);
      vecs[15] = mk(5'b10000, 5'b00100, 8'd0);
      vecs[16] = mk(5'b10001, 5'b00000, 8'd0);
      vecs[17] = mk(5'b10010, 5'b00000, 8'd0);
      vecs[18] = mk(5'b10000, 5'b00000, 8'd0);
      vecs[19] = mk(5'b01000, 5'b00000, 8'd0);
      vecs[20] = mk(5'b01000, 5'b00000, 8'd0);
      vecs[21] = mk(5'b01000, 5'b00000, 8'd0);

      #12;
      chk("reset_outputs", 16'(outs()), 16'h0000);
      #1 reset = 1'b0;

      for (int i = 0; i < 22; i++) begin
         step(vecs[i].in);
         chk($sformatf("vec%0d", i), 16'(outs()),
             16'({vecs[i].out, vecs[i].dc}));
      end

      // Host holds READ while two captures come due.
      for (int i = 0; i < 3; i++) step(5'b11000);
      chk("en_hold_no_due", 16'(bus.cap_grant), 16'd0);
      step(5'b11000);
      step(5'b10000);
      chk("cap3_start", 16'({bus.cap_start, bus.cap_grant}), 16'b11);
      step(5'b10100);
      chk("cap3_ready", 16'(bus.frame_ready), 16'd1);
      step(5'b10010);
      chk("read_grant", 16'({bus.host_grant, bus.frame_ready}), 16'b10);
      for (int i = 0; i < 8; i++) step(5'b11000);
      chk("read_held", 16'({bus.host_grant, bus.cap_grant}), 16'b10);
      chk("drop_one", 16'(bus.drop_count), 16'd1);
      step(5'b10001);
      chk("read_release", 16'({bus.host_grant, bus.cap_grant}), 16'b00);
      step(5'b10000);
      chk("pending_cap", 16'({bus.cap_start, bus.cap_grant}), 16'b11);
      step(5'b10100);
      chk("pending_done", 16'({bus.cap_grant, bus.frame_ready}), 16'b01);

      // Capture timeout after 16 cycles without cap_done.
      for (int i = 0; i < 4; i++) step(5'b11000);
      step(5'b10000);
      chk("tmo_enter", 16'(bus.cap_grant), 16'd1);
      for (int i = 0; i < 15; i++) step(5'b10000);
      chk("tmo_15", 16'({bus.cap_grant, bus.cap_timeout}), 16'b10);
      step(5'b10000);
      chk("tmo_hit", 16'({bus.cap_grant, bus.cap_timeout, bus.frame_ready}),
          16'b011);
      for (int i = 0; i < 3; i++) step(5'b10000);
      chk("tmo_sticky", 16'(bus.cap_timeout), 16'd1);
      step(5'b10010);
      chk("tmo_idle_read", 16'(bus.host_grant), 16'd1);
      step(5'b10001);

      // Reset in the middle of a capture, with frames already counted.
      for (int i = 0; i < 4; i++) step(5'b11000);
      step(5'b10000);
      chk("rst_cap_enter", 16'(bus.cap_grant), 16'd1);
      step(5'b11000);
      step(5'b11000);
      drive(5'b00000);
      #2 reset = 1'b1;
      #1;
      chk("rst_async", 16'(outs()), 16'h0000);
      @(posedge clk);
      #2 reset = 1'b0;
      for (int i = 0; i < 3; i++) step(5'b11000);
      step(5'b10000);
      chk("rst_cnt_cleared", 16'(bus.cap_grant), 16'd0);
      step(5'b11000);
      step(5'b10000);
      chk("rst_next_cap", 16'({bus.cap_start, bus.cap_grant}), 16'b11);

      // Saturating drop counter with the host parked in READ.
      step(5'b10100);
      step(5'b10010);
      chk("sat_read", 16'(bus.host_grant), 16'd1);
      for (int i = 0; i < 4; i++) step(5'b11000);
      for (int i = 0; i < 100 * 4; i++) step(5'b11000);
      chk("drop_100", 16'(bus.drop_count), 16'd100);
      for (int i = 0; i < 155 * 4; i++) step(5'b11000);
      chk("drop_255", 16'(bus.drop_count), 16'd255);
      for (int i = 0; i < 45 * 4; i++) step(5'b11000);
      chk("drop_sat", 16'(bus.drop_count), 16'd255);
      step(5'b10001);
      step(5'b10000);
      chk("sat_pending_cap", 16'({bus.cap_start, bus.cap_grant}), 16'b11);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
